vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_axis_counter.sv | 41 ++++
 rtl/vga_timing_gen.sv | 91 +++++++++
 tb/tb_vga_timing_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: the per-mode timing record, the default
// 640x480@60 mode, and helpers that derive the full line and frame lengths.
package vga_pkg;

    // Sync polarity fields: 1 = active-high, 0 = active-low.
    typedef struct packed {
        int unsigned h_visible;
        int unsigned h_front;
        int unsigned h_sync;
        int unsigned h_back;
        int unsigned v_visible;
        int unsigned v_front;
        int unsigned v_sync;
        int unsigned v_back;
        logic        h_sync_pol;
        logic        v_sync_pol;
    } vga_params_t;

    localparam vga_params_t VGA_640x480_60 = '{
        h_visible: 640, h_front: 16, h_sync: 96, h_back: 48,
        v_visible: 480, v_front: 10, v_sync: 2,  v_back: 33,
        h_sync_pol: 1'b0, v_sync_pol: 1'b0
    };

    function automatic int unsigned h_total(vga_params_t p);
        return p.h_visible + p.h_front + p.h_sync + p.h_back;
    endfunction

    function automatic int unsigned v_total(vga_params_t p);
        return p.v_visible + p.v_front + p.v_sync + p.v_back;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter advanced by tick_in, with
// decoded visible-region and (active-high) sync-window flags.
module vga_axis_counter #(
    parameter int unsigned visible = 640,
    parameter int unsigned front   = 16,
    parameter int unsigned sync    = 96,
    parameter int unsigned back    = 48,
    localparam int unsigned TOTAL  = visible + front + sync + back,
    localparam int          W      = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         tick_in,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         active,
    output logic         sync_active
);

    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] VIS_END = W'(visible);
    localparam logic [W-1:0] SYNC_LO = W'(visible + front);
    localparam logic [W-1:0] SYNC_HI = W'(visible + front + sync);

    assign wrap        = tick_in && (cnt == LAST);
    assign active      = (cnt < VIS_END);
    assign sync_active = (cnt >= SYNC_LO) && (cnt < SYNC_HI);

    // Position register: cleared while stopped, wraps after the last position.
    always_ff @(posedge clk) begin
        // NOTE: reset lives inside the clocked block (synchronous), and state uses <= so every
        // register samples pre-edge values regardless of block ordering.
        if (reset || !enable) begin
            cnt <= '0;
        end else if (tick_in) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster sequencer: issues the next pixel coordinate to the source and
// registers the returned pixel with both syncs and the start pulses so that
// every output leaves the block on the same edge.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter vga_params_t params = VGA_640x480_60,
    parameter int          XW     = $clog2(params.h_visible),
    parameter int          YW     = $clog2(params.v_visible)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic [XW-1:0] pixel_x_target_next,
    output logic [YW-1:0] pixel_y_target_next,
    output logic          fetch_valid,
    input  logic          pixel_value_next,
    output logic          h_sync,
    output logic          v_sync,
    output logic          pixel_signal,
    output logic          frame_start,
    output logic          line_start
);

    localparam int HW = $clog2(h_total(params));
    localparam int VW = $clog2(v_total(params));

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap;
    logic          h_active, v_active;
    logic          h_sync_act, v_sync_act;
    logic          visible;

    vga_axis_counter #(
        .visible (params.h_visible),
        .front   (params.h_front),
        .sync    (params.h_sync),
        .back    (params.h_back)
    ) u_h_axis (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .tick_in     (1'b1),
        .cnt         (h_cnt),
        .wrap        (h_wrap),
        .active      (h_active),
        .sync_active (h_sync_act)
    );

    // The vertical axis advances once per completed line.
    vga_axis_counter #(
        .visible (params.v_visible),
        .front   (params.v_front),
        .sync    (params.v_sync),
        .back    (params.v_back)
    ) u_v_axis (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .tick_in     (h_wrap),
        .cnt         (v_cnt),
        .wrap        (),
        .active      (v_active),
        .sync_active (v_sync_act)
    );

    // Fetch stage: coordinates are parked at zero during blanking.
    assign visible             = h_active && v_active;
    assign fetch_valid         = visible;
    assign pixel_x_target_next = visible ? h_cnt[XW-1:0] : '0;
    assign pixel_y_target_next = visible ? v_cnt[YW-1:0] : '0;

    // Output stage: one-cycle-late copy of the fetch stage; polarity applied here only.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            pixel_signal <= 1'b0;
            h_sync       <= ~params.h_sync_pol;
            v_sync       <= ~params.v_sync_pol;
            frame_start  <= 1'b0;
            line_start   <= 1'b0;
        end else begin
            pixel_signal <= visible & pixel_value_next;
            h_sync       <= h_sync_act ? params.h_sync_pol : ~params.h_sync_pol;
            v_sync       <= v_sync_act ? params.v_sync_pol : ~params.v_sync_pol;
            frame_start  <= (h_cnt == '0) && (v_cnt == '0);
            line_start   <= (h_cnt == '0) && v_active;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a default-mode instance checked against a table of
// hand-computed vectors and directed sequences, plus a tiny-mode instance
// (active-high vsync) checked every cycle against a reference model.
module tb_vga_timing_gen;
    import vga_pkg::*;

    // 16 x 11 raster: h 8/2/3/3 (sync at 10..12), v 6/1/2/2 (sync at 7..8).
    localparam vga_params_t SMALL = '{
        h_visible: 8, h_front: 2, h_sync: 3, h_back: 3,
        v_visible: 6, v_front: 1, v_sync: 2, v_back: 2,
        h_sync_pol: 1'b0, v_sync_pol: 1'b1
    };

    logic clk = 1'b0;
    logic reset, enable, pv_a, pv_b;

    logic [9:0] ax;
    logic [8:0] ay;
    logic       fva, hsa, vsa, pixa, fsa, lsa;
    logic [2:0] bx, by;
    logic       fvb, hsb, vsb, pixb, fsb, lsb;

    always #5 clk = ~clk;

    vga_timing_gen u_dut_a (
        .clk                 (clk),
        .reset               (reset),
        .enable              (enable),
        .pixel_x_target_next (ax),
        .pixel_y_target_next (ay),
        .fetch_valid         (fva),
        .pixel_value_next    (pv_a),
        .h_sync              (hsa),
        .v_sync              (vsa),
        .pixel_signal        (pixa),
        .frame_start         (fsa),
        .line_start          (lsa)
    );

    vga_timing_gen #(.params(SMALL)) u_dut_b (
        .clk                 (clk),
        .reset               (reset),
        .enable              (enable),
        .pixel_x_target_next (bx),
        .pixel_y_target_next (by),
        .fetch_valid         (fvb),
        .pixel_value_next    (pv_b),
        .h_sync              (hsb),
        .v_sync              (vsb),
        .pixel_signal        (pixb),
        .frame_start         (fsb),
        .line_start          (lsb)
    );

    typedef struct {
        int         k;      // enabled edges since (re)start
        logic       fv;
        logic [9:0] x;
        logic [8:0] y;
        logic [4:0] out;    // {h_sync, v_sync, frame_start, line_start, pixel_signal}
        string      name;
    } vec_t;

    vec_t tbl[12];

    int n_cmp = 0;
    int n_bad = 0;
    int a_k, a_mode, cyc;
    int b_h, b_v, b_fs_last;
    int hs_low, ls_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    function automatic logic b_vis(input int h, input int v);
        return (h < 8) && (v < 6);
    endfunction

    function automatic logic [4:0] b_out_exp(input int h, input int v, input logic pv);
        return {(h >= 10 && h < 13) ? 1'b0 : 1'b1,
                (v >= 7 && v < 9)   ? 1'b1 : 1'b0,
                (h == 0 && v == 0),
                (h == 0 && v < 6),
                b_vis(h, v) & pv};
    endfunction

    function automatic logic [6:0] b_tgt_exp(input int h, input int v);
        return b_vis(h, v) ? {1'b1, 3'(h), 3'(v)} : 7'd0;
    endfunction

    // Combinational source model for the small instance, driven from model coordinates.
    function automatic logic b_src(input int h, input int v);
        return b_vis(h, v) ? (h[0] ^ v[0]) : 1'b1;
    endfunction

    // One clock: sample away from the edge, update the small-mode model, re-drive sources.
    task automatic step();
        logic       r, e, p;
        logic [4:0] e_out;
        r = reset;
        e = enable;
        p = pv_b;
        @(posedge clk);
        #1;
        cyc++;
        a_k++;
        if (r || !e) begin
            e_out     = 5'b10000;
            b_h       = 0;
            b_v       = 0;
            b_fs_last = -1;
        end else begin
            e_out = b_out_exp(b_h, b_v, p);
            if (b_h == 15) begin
                b_h = 0;
                b_v = (b_v == 10) ? 0 : b_v + 1;
            end else begin
                b_h++;
            end
        end
        check("b_out", {27'd0, hsb, vsb, fsb, lsb, pixb}, {27'd0, e_out});
        check("b_tgt", {25'd0, fvb, bx, by}, {25'd0, b_tgt_exp(b_h, b_v)});
        if (fsb) begin
            if (b_fs_last >= 0) check("b_frame_period", cyc - b_fs_last, 176);
            b_fs_last = cyc;
        end
        pv_b = b_src(b_h, b_v);
        pv_a = (a_mode != 0) ? (ax[0] | ~fva) : 1'b1;
    endtask

    task automatic run_table();
        for (int i = 0; i < 12; i++) begin
            for (int g = 0; g < 2000 && a_k < tbl[i].k; g++) step();
            check({tbl[i].name, "/tgt"}, {12'd0, fva, ax, ay}, {12'd0, tbl[i].fv, tbl[i].x, tbl[i].y});
            check({tbl[i].name, "/out"}, {27'd0, hsa, vsa, fsa, lsa, pixa}, {27'd0, tbl[i].out});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Source drives x[0] while visible and 1 during blanking.
        tbl[0]  = '{2,    1'b1, 10'd2,   9'd0, 5'b11001, "x1_pix"};
        tbl[1]  = '{3,    1'b1, 10'd3,   9'd0, 5'b11000, "x2_pix"};
        tbl[2]  = '{640,  1'b0, 10'd0,   9'd0, 5'b11001, "x639_last"};
        tbl[3]  = '{641,  1'b0, 10'd0,   9'd0, 5'b11000, "blank_pix0"};
        tbl[4]  = '{656,  1'b0, 10'd0,   9'd0, 5'b11000, "pre_hsync"};
        tbl[5]  = '{657,  1'b0, 10'd0,   9'd0, 5'b01000, "hsync_first"};
        tbl[6]  = '{752,  1'b0, 10'd0,   9'd0, 5'b01000, "hsync_last"};
        tbl[7]  = '{753,  1'b0, 10'd0,   9'd0, 5'b11000, "post_hsync"};
        tbl[8]  = '{800,  1'b1, 10'd0,   9'd1, 5'b11000, "line_end"};
        tbl[9]  = '{801,  1'b1, 10'd1,   9'd1, 5'b11010, "line1_start"};
        tbl[10] = '{802,  1'b1, 10'd2,   9'd1, 5'b11001, "line1_x1"};
        tbl[11] = '{1279, 1'b1, 10'd479, 9'd1, 5'b11000, "line1_x478"};

        reset     = 1'b1;
        enable    = 1'b1;
        a_mode    = 0;
        pv_a      = 1'b1;
        b_h       = 0;
        b_v       = 0;
        b_fs_last = -1;
        cyc       = 0;
        pv_b      = b_src(0, 0);

        repeat (3) step();
        check("a_rst_out", {27'd0, hsa, vsa, fsa, lsa, pixa}, 32'b11000);
        check("a_rst_tgt", {12'd0, fva, ax, ay}, {12'd0, 1'b1, 19'd0});

        // First edge out of reset with a constant-1 source.
        reset = 1'b0;
        a_k   = 0;
        step();
        check("a_first_out", {27'd0, hsa, vsa, fsa, lsa, pixa}, 32'b11111);
        check("a_first_tgt", {12'd0, fva, ax, ay}, {12'd0, 1'b1, 10'd1, 9'd0});

        a_mode = 1;
        pv_a   = ax[0] | ~fva;
        run_table();

        // Any 800 consecutive outputs hold 96 h_sync-low cycles and one line_start.
        hs_low = 0;
        ls_cnt = 0;
        repeat (800) begin
            step();
            if (!hsa) hs_low++;
            if (lsa) ls_cnt++;
        end
        check("a_hsync_width", hs_low, 96);
        check("a_line_start_count", ls_cnt, 1);

        // Stop mid-line for 50 cycles, then restart from (0,0).
        for (int g = 0; g < 2000 && a_k < 2100; g++) step();
        enable = 1'b0;
        repeat (50) begin
            step();
            check("a_idle", {7'd0, hsa, vsa, fsa, lsa, pixa, fva, ax, ay},
                  {7'd0, 5'b11000, 1'b1, 19'd0});
        end
        enable = 1'b1;
        a_k    = 0;
        step();
        check("a_restart_out", {27'd0, hsa, vsa, fsa, lsa, pixa}, 32'b11110);
        check("a_restart_tgt", {12'd0, fva, ax, ay}, {12'd0, 1'b1, 10'd1, 9'd0});
        run_table();

        // Small mode: reset while inside the (active-high) vertical sync.
        for (int g = 0; g < 400 && !(b_v == 7 && b_h == 5); g++) step();
        check("b_in_vsync", {31'd0, vsb}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("b_rst_vsync", {31'd0, vsb}, 32'd0);
        check("b_rst_pix", {31'd0, pixb}, 32'd0);
        check("b_rst_tgt", {25'd0, fvb, bx, by}, {25'd0, 1'b1, 6'd0});

        // Small mode: double wrap at the last position of the frame.
        step();
        for (int g = 0; g < 400 && !(b_v == 10 && b_h == 15); g++) step();
        step();
        check("b_wrap_tgt", {25'd0, fvb, bx, by}, {25'd0, 1'b1, 6'd0});
        check("b_wrap_fs_pre", {31'd0, fsb}, 32'd0);
        step();
        check("b_wrap_fs", {31'd0, fsb}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
